shiftseq: RTL

- Sequencer that sits directly upstream of the N-bit load/shift-left/shift-right register and drives its control inputs.
- Accepts parallel words over a valid/ready handshake and commands one parallel load followed by N shifts.
- Reads the register's parallel output back and presents the outgoing edge bit as a serial stream with valid/ready flow control.
- Emits a one-cycle done pulse per completed word.

---
 rtl/shiftseq.sv | 94 +++++++++
 1 files changed

// File: rtl/shiftseq.sv
// shiftseq: feeds words into an external load/shift register and streams its edge bit out with valid/ready.
module shiftseq #(
  parameter int N  = 4,
  parameter int CW = 3
) (
  input  logic         ck,
  input  logic         rn,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  input  logic         in_dir,
  input  logic         fill,
  output logic         sr_load,
  output logic         sr_dir,
  output logic [N-1:0] sr_pinp,
  output logic         sr_linp,
  output logic         sr_rinp,
  input  logic [N-1:0] sr_out,
  output logic         sout,
  output logic         sout_valid,
  input  logic         sout_ready,
  output logic         done
);
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;
  state_t        state_q, state_d;
  logic [N-1:0]  word_q, word_d;
  logic          dir_q, dir_d, fill_q, fill_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last;
  assign last    = cnt_q == CW'(N-1);
  assign sr_dir  = dir_q;
  assign sr_linp = fill_q;
  assign sr_rinp = fill_q;
  always_ff @(posedge ck or negedge rn) begin
    if (!rn) begin
      state_q <= IDLE;
      word_q  <= '0;
      dir_q   <= 1'b0;
      fill_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      dir_q   <= dir_d;
      fill_q  <= fill_d;
      cnt_q   <= cnt_d;
    end
  end
  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    dir_d      = dir_q;
    fill_d     = fill_q;
    cnt_d      = cnt_q;
    in_ready   = 1'b0;
    sr_load    = 1'b0;
    sr_pinp    = '0;
    sout       = 1'b0;
    sout_valid = 1'b0;
    done       = 1'b0;
    case (state_q)
      IDLE: in_ready = rn;
      LOAD: begin
        sr_load = 1'b1;
        sr_pinp = word_q;
        cnt_d   = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        sout_valid = 1'b1;
        sout       = dir_q ? sr_out[0] : sr_out[N-1];
        if (sout_ready) begin
          cnt_d = cnt_q + CW'(1);
          if (last) begin
            done     = 1'b1;
            in_ready = 1'b1;
            state_d  = IDLE;
          end
        end else begin
          // stall: the register reloads its own contents so the edge bit holds
          sr_load = 1'b1;
          sr_pinp = sr_out;
        end
      end
      default: state_d = IDLE;
    endcase
    if (in_ready && in_valid) begin
      word_d  = in_data;
      dir_d   = in_dir;
      fill_d  = fill;
      state_d = LOAD;
    end
  end
endmodule
